// File: rtl/move_pkg.sv
// Shared definitions for the ant move retracer: move codes, FSM states and helpers.
package move_pkg;

  localparam int unsigned MoveWidth = 3;

  localparam logic [MoveWidth-1:0] MvNone = 3'd0;
  localparam logic [MoveWidth-1:0] MvN    = 3'd1;
  localparam logic [MoveWidth-1:0] MvE    = 3'd2;
  localparam logic [MoveWidth-1:0] MvS    = 3'd3;
  localparam logic [MoveWidth-1:0] MvW    = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StWait,
    StIssue,
    StDone
  } state_e;

  // Opposite direction; NONE and reserved codes map to NONE.
  function automatic logic [MoveWidth-1:0] inverse_move(input logic [MoveWidth-1:0] m);
    logic [MoveWidth-1:0] r;
    r = MvNone;
    case (m)
      MvN:     r = MvS;
      MvS:     r = MvN;
      MvE:     r = MvW;
      MvW:     r = MvE;
      default: r = MvNone;
    endcase
    return r;
  endfunction

  function automatic logic is_dir(input logic [MoveWidth-1:0] m);
    return (m == MvN) || (m == MvE) || (m == MvS) || (m == MvW);
  endfunction

  // 6-bit counter increment that sticks at 63.
  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

endpackage

// File: rtl/move_inverter.sv
// Combinational move decoder: produces the inverse direction and a valid-direction flag.
module move_inverter
  import move_pkg::*;
(
  input  logic [MoveWidth-1:0] code_i,
  output logic [MoveWidth-1:0] inv_o,
  output logic                 is_dir_o
);

  // Pure lookup through the package helpers.
  always_comb begin
    inv_o    = inverse_move(code_i);
    is_dir_o = is_dir(code_i);
  end

endmodule

// File: rtl/move_retracer.sv
// Pops recorded ant moves, inverts them and hands each inverted step to the position unit.
module move_retracer
  import move_pkg::*;
#(
  parameter int unsigned W       = MoveWidth,
  parameter int unsigned S       = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         stack_empty,
  output logic         pop,
  input  logic         pop_valid,
  input  logic [W-1:0] pop_move,
  output logic         step_valid,
  input  logic         step_ready,
  output logic [W-1:0] step_dir,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [5:0]   steps,
  output logic [5:0]   bad
);

  localparam int unsigned PcW  = $clog2(S + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [PcW-1:0]  pop_cnt_q, pop_cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [W-1:0]    step_dir_q, step_dir_d;
  logic [5:0]      steps_q, steps_d;
  logic [5:0]      bad_q, bad_d;
  logic            err_q, err_d;
  logic            pop_q, pop_d;
  logic            step_valid_q, step_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [W-1:0]    inv_code;
  logic            code_is_dir;
  state_e          np_state;
  logic            np_err;

  move_inverter u_inverter (
    .code_i   (pop_move),
    .inv_o    (inv_code),
    .is_dir_o (code_is_dir)
  );

  // Shared decision taken after each step or discarded code: stop, stop with error, or pop again.
  always_comb begin
    np_state = StPop;
    np_err   = 1'b0;
    if (stack_empty) begin
      np_state = StDone;
    end else if (pop_cnt_q == PcW'(S)) begin
      np_state = StDone;
      np_err   = 1'b1;
    end
  end

  // Next-state and datapath updates; outputs are decoded from the next state so they register.
  always_comb begin
    state_d    = state_q;
    pop_cnt_d  = pop_cnt_q;
    tmo_d      = tmo_q;
    step_dir_d = step_dir_q;
    steps_d    = steps_q;
    bad_d      = bad_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pop_cnt_d = '0;
          steps_d   = '0;
          bad_d     = '0;
          err_d     = 1'b0;
          state_d   = stack_empty ? StDone : StPop;
        end
      end
      StPop: begin
        if (abort) begin
          state_d = StDone;
        end else begin
          pop_cnt_d = pop_cnt_q + PcW'(1);
          tmo_d     = '0;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (abort) begin
          state_d = StDone;
        end else if (pop_valid) begin
          if (code_is_dir) begin
            step_dir_d = inv_code;
            state_d    = StIssue;
          end else begin
            bad_d   = sat_inc6(bad_q);
            err_d   = err_q | np_err;
            state_d = np_state;
          end
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StIssue: begin
        if (abort) begin
          state_d = StDone;
        end else if (step_ready) begin
          steps_d = sat_inc6(steps_q);
          err_d   = err_q | np_err;
          state_d = np_state;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    pop_d        = (state_d == StPop);
    step_valid_d = (state_d == StIssue);
    busy_d       = (state_d != StIdle);
    done_d       = (state_d == StDone);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pop_cnt_q    <= '0;
      tmo_q        <= '0;
      step_dir_q   <= '0;
      steps_q      <= '0;
      bad_q        <= '0;
      err_q        <= 1'b0;
      pop_q        <= 1'b0;
      step_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pop_cnt_q    <= pop_cnt_d;
      tmo_q        <= tmo_d;
      step_dir_q   <= step_dir_d;
      steps_q      <= steps_d;
      bad_q        <= bad_d;
      err_q        <= err_d;
      pop_q        <= pop_d;
      step_valid_q <= step_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign pop        = pop_q;
  assign step_valid = step_valid_q;
  assign step_dir   = step_dir_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign steps      = steps_q;
  assign bad        = bad_q;

endmodule

// File: tb/tb_move_retracer.sv
// Directed bench for move_retracer and move_inverter with a small behavioural move stack.
module tb_move_retracer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main DUT (S = 32)
  logic       start, abort, stack_empty, pop, pop_valid, step_valid, step_ready;
  logic       busy, done, err;
  logic [2:0] pop_move, step_dir;
  logic [5:0] steps, bad;

  // Second DUT with S = 4 and a never-empty stack
  logic       start2, abort2, stack_empty2, pop2, pv2, step_valid2, step_ready2;
  logic       busy2, done2, err2;
  logic [2:0] pop_move2, step_dir2;
  logic [5:0] steps2, bad2;

  // Inverter unit
  logic [2:0] inv_code, inv_out;
  logic       inv_isdir;

  move_retracer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stack_empty(stack_empty),
    .pop(pop), .pop_valid(pop_valid), .pop_move(pop_move), .step_valid(step_valid),
    .step_ready(step_ready), .step_dir(step_dir), .busy(busy), .done(done), .err(err),
    .steps(steps), .bad(bad)
  );

  move_retracer #(.S(4)) dut_s4 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .stack_empty(stack_empty2),
    .pop(pop2), .pop_valid(pv2), .pop_move(pop_move2), .step_valid(step_valid2),
    .step_ready(step_ready2), .step_dir(step_dir2), .busy(busy2), .done(done2), .err(err2),
    .steps(steps2), .bad(bad2)
  );

  move_inverter u_inv (.code_i(inv_code), .inv_o(inv_out), .is_dir_o(inv_isdir));

  // Stack model: answers a pop one cycle later unless pv_en is low.
  logic [2:0] mem [8];
  logic [2:0] ld_mem [8];
  int         sp = 0;
  int         ld_sp = 0;
  logic       ld = 1'b0;
  logic       pv_en = 1'b1;

  assign stack_empty = (sp == 0);

  always @(posedge clk) begin
    pop_valid <= 1'b0;
    if (ld) begin
      for (int i = 0; i < 8; i++) mem[i] <= ld_mem[i];
      sp <= ld_sp;
    end else if (pop && pv_en && sp > 0) begin
      pop_valid <= 1'b1;
      pop_move  <= mem[sp-1];
      sp        <= sp - 1;
    end
  end

  assign abort2       = 1'b0;
  assign stack_empty2 = 1'b0;
  assign step_ready2  = 1'b1;
  assign pop_move2    = 3'd1;
  always @(posedge clk) pv2 <= pop2;

  // Cycle counter and negedge monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         pop_n = 0, hs_n = 0, stall_n = 0, unstable_n = 0, done_n = 0;
  int         done_cyc = 0, pop2_n = 0, done2_n = 0;
  logic       done_err, done_busy, done2_err;
  logic [5:0] done_steps, done_bad, done2_steps;
  logic [2:0] hs_dir [64];
  int         hs_cyc [64];
  logic       prev_stall = 1'b0, prev_abort = 1'b0;
  logic [2:0] prev_dir = 3'd0;

  always @(negedge clk) begin
    if (pop === 1'b1) pop_n++;
    if (step_valid === 1'b1 && step_ready === 1'b1 && hs_n < 64) begin
      hs_dir[hs_n] = step_dir;
      hs_cyc[hs_n] = cyc;
      hs_n++;
    end
    if (step_valid === 1'b1 && step_ready === 1'b0) stall_n++;
    if (prev_stall && !prev_abort && (step_valid !== 1'b1 || step_dir !== prev_dir))
      unstable_n++;
    if (done === 1'b1) begin
      done_n++;
      done_cyc   = cyc;
      done_err   = err;
      done_busy  = busy;
      done_steps = steps;
      done_bad   = bad;
    end
    if (pop2 === 1'b1) pop2_n++;
    if (done2 === 1'b1) begin
      done2_n++;
      done2_err   = err2;
      done2_steps = steps2;
    end
    prev_stall = (step_valid === 1'b1 && step_ready === 1'b0);
    prev_abort = (abort === 1'b1);
    prev_dir   = step_dir;
  end

  int ncmp = 0;
  int nfail = 0;
  int t0, p0, h0, d0, s0, u0;
  logic [2:0] exp_inv [8];
  logic       exp_dir [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int n, input logic [2:0] a, b, c, d);
    ld_mem[0] = a; ld_mem[1] = b; ld_mem[2] = c; ld_mem[3] = d;
    for (int i = 4; i < 8; i++) ld_mem[i] = 3'd0;
    ld_sp = n;
    tick(1);
    ld = 1'b1;
    tick(1);
    ld = 1'b0;
  endtask

  // Start pulse held through cycle 0; returns in cycle 1.
  task automatic do_start();
    tick(1);
    start = 1'b1;
    t0    = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base, input int maxc);
    int k = 0;
    while (done_n == base && k < maxc) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, done_n - base, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; step_ready = 1'b0; start2 = 1'b0;
    inv_code = 3'd0;

    // Inverter unit: 0 NONE, 1 N, 2 E, 3 S, 4 W, 5-7 reserved
    exp_inv[0] = 3'd0; exp_inv[1] = 3'd3; exp_inv[2] = 3'd4; exp_inv[3] = 3'd1;
    exp_inv[4] = 3'd2; exp_inv[5] = 3'd0; exp_inv[6] = 3'd0; exp_inv[7] = 3'd0;
    exp_dir[0] = 1'b0; exp_dir[1] = 1'b1; exp_dir[2] = 1'b1; exp_dir[3] = 1'b1;
    exp_dir[4] = 1'b1; exp_dir[5] = 1'b0; exp_dir[6] = 1'b0; exp_dir[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      inv_code = 3'(i);
      #1;
      chk($sformatf("inv_isdir_%0d", i), inv_isdir, exp_dir[i]);
      if (i >= 1 && i <= 4) chk($sformatf("inv_code_%0d", i), inv_out, exp_inv[i]);
    end

    // Reset state
    tick(2);
    chk("rst_pop", pop, 0);
    chk("rst_step_valid", step_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_step_dir", step_dir, 0);
    chk("rst_steps", steps, 0);
    chk("rst_bad", bad, 0);
    rst = 1'b0;
    tick(2);
    chk("idle_busy", busy, 0);

    // T1: stack N,E,E (top E), ready always high -> W,W,S, done at cycle 10
    load(3, 3'd1, 3'd2, 3'd2, 3'd0);
    pv_en = 1'b1; step_ready = 1'b1;
    p0 = pop_n; h0 = hs_n; d0 = done_n;
    do_start();
    chk("t1_pop_c1", pop, 1);
    wait_done("t1_done_seen", d0, 40);
    chk("t1_done_cycle", done_cyc - t0, 10);
    chk("t1_hs_count", hs_n - h0, 3);
    chk("t1_dir0", hs_dir[h0], 3'd4);
    chk("t1_dir1", hs_dir[h0+1], 3'd4);
    chk("t1_dir2", hs_dir[h0+2], 3'd3);
    chk("t1_hs0_cycle", hs_cyc[h0] - t0, 3);
    chk("t1_hs1_cycle", hs_cyc[h0+1] - t0, 6);
    chk("t1_pops", pop_n - p0, 3);
    chk("t1_steps", done_steps, 3);
    chk("t1_bad", done_bad, 0);
    chk("t1_err", done_err, 0);
    chk("t1_busy_at_done", done_busy, 1);
    tick(1);
    chk("t1_busy_after", busy, 0);
    chk("t1_steps_hold", steps, 3);

    // T2: pop_valid never returns -> err, done TIMEOUT cycles after WAIT entry (cycle 2)
    load(2, 3'd1, 3'd2, 3'd0, 3'd0);
    pv_en = 1'b0;
    p0 = pop_n; d0 = done_n;
    do_start();
    wait_done("t2_done_seen", d0, 60);
    chk("t2_done_cycle", done_cyc - t0, 17);
    chk("t2_err", done_err, 1);
    chk("t2_pops", pop_n - p0, 1);
    tick(3);
    chk("t2_err_sticky", err, 1);
    chk("t2_idle", busy, 0);

    // T3: start with empty stack -> no pop, done at cycle 1, err cleared
    load(0, 3'd0, 3'd0, 3'd0, 3'd0);
    pv_en = 1'b1;
    p0 = pop_n; d0 = done_n;
    do_start();
    wait_done("t3_done_seen", d0, 10);
    chk("t3_done_cycle", done_cyc - t0, 1);
    chk("t3_pops", pop_n - p0, 0);
    chk("t3_err", done_err, 0);
    chk("t3_steps", done_steps, 0);

    // T4: stack S,0,7,N (top N) -> S then N, bad=2; a start in POP is ignored
    load(4, 3'd3, 3'd0, 3'd7, 3'd1);
    p0 = pop_n; h0 = hs_n; d0 = done_n;
    do_start();
    tick(3);
    chk("t4_busy_c4", busy, 1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("t4_done_seen", d0, 60);
    chk("t4_hs_count", hs_n - h0, 2);
    chk("t4_dir0", hs_dir[h0], 3'd3);
    chk("t4_dir1", hs_dir[h0+1], 3'd1);
    chk("t4_bad", done_bad, 2);
    chk("t4_steps", done_steps, 2);
    chk("t4_pops", pop_n - p0, 4);
    chk("t4_done_cycle", done_cyc - t0, 11);

    // T5: stack W,N (top N), ready low for cycles 3..7 -> held S, accepted at cycle 8
    load(2, 3'd4, 3'd1, 3'd0, 3'd0);
    step_ready = 1'b0;
    p0 = pop_n; h0 = hs_n; d0 = done_n; s0 = stall_n; u0 = unstable_n;
    do_start();
    tick(4);
    chk("t5_valid_c5", step_valid, 1);
    chk("t5_dir_c5", step_dir, 3'd3);
    tick(3);
    chk("t5_pops_before_hs", pop_n - p0, 1);
    step_ready = 1'b1;
    wait_done("t5_done_seen", d0, 40);
    chk("t5_stall_cycles", stall_n - s0, 5);
    chk("t5_unstable", unstable_n - u0, 0);
    chk("t5_hs0_cycle", hs_cyc[h0] - t0, 8);
    chk("t5_dir0", hs_dir[h0], 3'd3);
    chk("t5_dir1", hs_dir[h0+1], 3'd2);
    chk("t5_done_cycle", done_cyc - t0, 12);

    // T6: abort in ISSUE -> step_valid low next cycle together with done
    load(3, 3'd1, 3'd2, 3'd2, 3'd0);
    step_ready = 1'b0;
    p0 = pop_n; h0 = hs_n;
    do_start();
    tick(3);
    chk("t6_valid_in_issue", step_valid, 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t6_valid_after_abort", step_valid, 0);
    chk("t6_done", done, 1);
    tick(1);
    chk("t6_busy_after", busy, 0);
    chk("t6_done_once", done, 0);
    chk("t6_no_hs", hs_n - h0, 0);
    chk("t6_pops", pop_n - p0, 1);

    // T7: reset mid-WAIT after one accepted step
    load(2, 3'd1, 3'd2, 3'd0, 3'd0);
    pv_en = 1'b1; step_ready = 1'b1;
    d0 = done_n;
    do_start();
    tick(2);
    pv_en = 1'b0;
    tick(3);
    chk("t7_busy_wait", busy, 1);
    chk("t7_steps_pre", steps, 1);
    chk("t7_dir_pre", step_dir, 3'd4);
    rst = 1'b1;
    #1;
    chk("t7_pop", pop, 0);
    chk("t7_step_valid", step_valid, 0);
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    chk("t7_err", err, 0);
    chk("t7_step_dir", step_dir, 0);
    chk("t7_steps", steps, 0);
    chk("t7_bad", bad, 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("t7_no_done_pulse", done_n - d0, 0);
    pv_en = 1'b1;

    // T8: S=4 instance, stack never empty -> 4 pops, done with err
    p0 = pop2_n; d0 = done2_n;
    tick(1);
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    for (int k = 0; k < 60 && done2_n == d0; k++) tick(1);
    chk("t8_done_seen", done2_n - d0, 1);
    chk("t8_pops", pop2_n - p0, 4);
    chk("t8_err", done2_err, 1);
    chk("t8_steps", done2_steps, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
